// File: rtl/mem_bus_arbiter.sv
// Arbitrates one synchronous memory port between instruction fetch and load/store.
// LS has priority; a starvation counter forces a fetch grant after MAX_WAIT LS wins.
module mem_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rest,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [DATA_W/8-1:0] ls_be_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                hold_o
);

  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(MAX_WAIT);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;
  logic       r_owner;
  logic       w_owner_nx;
  logic       r_we_q;
  logic       w_we_nx;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nx;
  logic [3:0] r_starve;
  logic [3:0] w_starve_nx;

  logic w_done;
  logic w_dec;
  logic w_if_win;
  logic w_ls_win;

  // r_owner: 1 = LS, 0 = IF
  always_ff @(posedge clk) begin
    if (rest) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_we_q   <= 1'b0;
      r_cnt    <= '0;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_owner  <= w_owner_nx;
      r_we_q   <= w_we_nx;
      r_cnt    <= w_cnt_nx;
      r_starve <= w_starve_nx;
    end
  end

  assign w_done   = (r_state == S_WAIT) && (r_cnt == LAT);
  assign w_dec    = (r_state == S_IDLE) || w_done;
  assign w_if_win = if_req_i && (!ls_req_i || (r_starve == SMAX));
  assign w_ls_win = ls_req_i && !w_if_win;

  always_comb begin
    w_state_nx  = r_state;
    w_owner_nx  = r_owner;
    w_we_nx     = r_we_q;
    w_cnt_nx    = r_cnt;
    w_starve_nx = r_starve;
    if_gnt_o    = 1'b0;
    ls_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    ls_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    ls_rdata_o  = '0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    hold_o      = 1'b0;
    if (!rest) begin
      if (w_done) begin
        if (r_owner) begin
          ls_rvalid_o = 1'b1;
          ls_rdata_o  = r_we_q ? '0 : mem_rdata_i;
        end else begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = r_we_q ? '0 : mem_rdata_i;
        end
      end
      if (w_dec && (w_if_win || w_ls_win)) begin
        mem_en_o   = 1'b1;
        w_state_nx = S_WAIT;
        w_cnt_nx   = 3'd1;
        w_owner_nx = w_ls_win;
        if (w_ls_win) begin
          ls_gnt_o    = 1'b1;
          mem_we_o    = ls_we_i;
          mem_be_o    = ls_be_i;
          mem_addr_o  = ls_addr_i;
          mem_wdata_o = ls_wdata_i;
        end else begin
          if_gnt_o   = 1'b1;
          mem_addr_o = if_addr_i;
        end
        w_we_nx = mem_we_o;
      end else if (w_done) begin
        w_state_nx = S_IDLE;
      end else if (r_state == S_WAIT) begin
        w_cnt_nx = r_cnt + 3'd1;
      end
      if (w_dec) begin
        if (if_req_i && w_ls_win)
          w_starve_nx = (r_starve == SMAX) ? SMAX : r_starve + 4'd1;
        else
          w_starve_nx = '0;
      end
      hold_o = (ls_req_i && !ls_gnt_o)
             || ((r_state == S_WAIT) && r_owner && !ls_rvalid_o);
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter at memory latencies 1, 2 and 3.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rest;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] k_rd;

  int total;
  int bad;

  logic        a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid;
  logic [31:0] a_if_rdata, a_ls_rdata;
  logic        a_mem_en, a_mem_we, a_hold;
  logic [3:0]  a_mem_be;
  logic [31:0] a_mem_addr, a_mem_wdata, a_rd;

  logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid;
  logic [31:0] b_if_rdata, b_ls_rdata;
  logic        b_mem_en, b_mem_we, b_hold;
  logic [3:0]  b_mem_be;
  logic [31:0] b_mem_addr, b_mem_wdata;

  logic        c_if_gnt, c_if_rvalid, c_ls_gnt, c_ls_rvalid;
  logic [31:0] c_if_rdata, c_ls_rdata;
  logic        c_mem_en, c_mem_we, c_hold;
  logic [3:0]  c_mem_be;
  logic [31:0] c_mem_addr, c_mem_wdata;

  logic [31:0] mem [0:63];

  mem_bus_arbiter #(.MEM_LAT(1), .MAX_WAIT(4)) u_a (
    .clk(clk), .rest(rest),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(a_if_gnt),
    .if_rvalid_o(a_if_rvalid), .if_rdata_o(a_if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be),
    .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata), .ls_gnt_o(a_ls_gnt),
    .ls_rvalid_o(a_ls_rvalid), .ls_rdata_o(a_ls_rdata),
    .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_be_o(a_mem_be),
    .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata),
    .mem_rdata_i(a_rd), .hold_o(a_hold)
  );

  mem_bus_arbiter #(.MEM_LAT(2), .MAX_WAIT(4)) u_b (
    .clk(clk), .rest(rest),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(b_if_gnt),
    .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be),
    .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata), .ls_gnt_o(b_ls_gnt),
    .ls_rvalid_o(b_ls_rvalid), .ls_rdata_o(b_ls_rdata),
    .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_be_o(b_mem_be),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
    .mem_rdata_i(k_rd), .hold_o(b_hold)
  );

  mem_bus_arbiter #(.MEM_LAT(3), .MAX_WAIT(4)) u_c (
    .clk(clk), .rest(rest),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(c_if_gnt),
    .if_rvalid_o(c_if_rvalid), .if_rdata_o(c_if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be),
    .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata), .ls_gnt_o(c_ls_gnt),
    .ls_rvalid_o(c_ls_rvalid), .ls_rdata_o(c_ls_rdata),
    .mem_en_o(c_mem_en), .mem_we_o(c_mem_we), .mem_be_o(c_mem_be),
    .mem_addr_o(c_mem_addr), .mem_wdata_o(c_mem_wdata),
    .mem_rdata_i(k_rd), .hold_o(c_hold)
  );

  always #5 clk = ~clk;

  // latency-1 memory with byte-enabled writes behind instance a
  always @(posedge clk) begin
    if (rest) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[4] <= 32'h0050_0093;
      a_rd   <= '0;
    end else if (a_mem_en) begin
      if (a_mem_we) begin
        for (int b = 0; b < 4; b++)
          if (a_mem_be[b])
            mem[a_mem_addr[7:2]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
      end else begin
        a_rd <= mem[a_mem_addr[7:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rest   = 1'b1;
    if_req = 1'b0;
    ls_req = 1'b0;
    ls_we  = 1'b0;
    nxt();
    rest = 1'b0;
  endtask

  logic [9:0] ifwin;

  initial begin
    total    = 0;
    bad      = 0;
    clk      = 1'b0;
    k_rd     = 32'h1234_5678;
    rest     = 1'b1;
    if_req   = 1'b1;
    ls_req   = 1'b1;
    if_addr  = 32'h10;
    ls_addr  = 32'h20;
    ls_we    = 1'b0;
    ls_be    = 4'hf;
    ls_wdata = 32'h1122_3344;
    ifwin    = 10'b10_0001_0000;

    repeat (3) begin
      smp();
      chk("rst_ctl", {a_if_gnt, a_ls_gnt, a_if_rvalid, a_ls_rvalid,
                      a_mem_en, a_mem_we, a_hold, a_mem_be}, 64'h0);
      chk("rst_addr", a_mem_addr, 64'h0);
      chk("rst_b", {b_ls_gnt, b_if_gnt, b_hold, b_mem_en}, 64'h0);
      nxt();
    end
    rest = 1'b0;
    smp();
    chk("rel_ls_gnt", a_ls_gnt, 1);
    chk("rel_if_gnt", a_if_gnt, 0);
    nxt();
    ls_req = 1'b0;
    smp();
    chk("rel_ls_rvalid", a_ls_rvalid, 1);
    chk("rel_if_gnt2", a_if_gnt, 1);
    nxt();
    if_req = 1'b0;
    smp();
    chk("rel_if_rvalid", a_if_rvalid, 1);
    chk("rel_if_rdata", a_if_rdata, 32'h0050_0093);
    nxt();

    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h10;
    smp();
    chk("sf_gnt", {a_if_gnt, a_mem_en, a_mem_we}, 3'b110);
    chk("sf_addr", a_mem_addr, 32'h10);
    chk("sf_hold0", a_hold, 0);
    nxt();
    if_req = 1'b0;
    smp();
    chk("sf_rvalid", a_if_rvalid, 1);
    chk("sf_rdata", a_if_rdata, 32'h0050_0093);
    chk("sf_hold1", a_hold, 0);
    chk("sf_en_idle", a_mem_en, 0);
    nxt();

    do_reset();
    if_req  = 1'b1;
    ls_req  = 1'b1;
    if_addr = 32'h30;
    ls_addr = 32'h34;
    smp();
    chk("ct_gnt_n", {b_ls_gnt, b_if_gnt}, 2'b10);
    chk("ct_addr_n", b_mem_addr, 32'h34);
    nxt();
    ls_req = 1'b0;
    smp();
    chk("ct_hold_n1", b_hold, 1);
    chk("ct_quiet_n1", {b_if_gnt, b_ls_rvalid, b_mem_en}, 3'b000);
    nxt();
    smp();
    chk("ct_n2", {b_ls_rvalid, b_if_gnt, b_hold}, 3'b110);
    chk("ct_ls_rdata", b_ls_rdata, 32'h1234_5678);
    chk("ct_if_addr", b_mem_addr, 32'h30);
    nxt();
    if_req = 1'b0;
    smp();
    chk("ct_if_rv_n3", b_if_rvalid, 0);
    nxt();
    smp();
    chk("ct_if_rv_n4", b_if_rvalid, 1);
    chk("ct_if_rdata", b_if_rdata, 32'h1234_5678);
    nxt();

    do_reset();
    if_req = 1'b1;
    ls_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      smp();
      chk($sformatf("starve_%0d", i), {a_if_gnt, a_ls_gnt},
          ifwin[i] ? 2'b10 : 2'b01);
      nxt();
    end
    if_req = 1'b0;
    ls_req = 1'b0;

    do_reset();
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_be    = 4'b0011;
    ls_addr  = 32'h20;
    ls_wdata = 32'hDEAD_BEEF;
    smp();
    chk("st_cmd", {a_ls_gnt, a_mem_en, a_mem_we, a_mem_be}, 7'b111_0011);
    chk("st_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    nxt();
    ls_we = 1'b0;
    ls_be = 4'hf;
    smp();
    chk("st_done", {a_ls_rvalid, a_ls_gnt, a_mem_we, a_hold}, 4'b1100);
    chk("st_rdata", a_ls_rdata, 0);
    nxt();
    ls_req = 1'b0;
    smp();
    chk("ld_rvalid", a_ls_rvalid, 1);
    chk("ld_rdata", a_ls_rdata, 32'h0000_BEEF);
    nxt();

    do_reset();
    ls_req  = 1'b1;
    ls_addr = 32'h40;
    smp();
    chk("mf_gnt", c_ls_gnt, 1);
    nxt();
    ls_req = 1'b0;
    rest   = 1'b1;
    smp();
    chk("mf_rst_out", {c_ls_rvalid, c_ls_gnt, c_hold, c_mem_en}, 4'b0000);
    nxt();
    rest    = 1'b0;
    ls_req  = 1'b1;
    ls_addr = 32'h44;
    smp();
    chk("mf_regnt", c_ls_gnt, 1);
    chk("mf_addr", c_mem_addr, 32'h44);
    nxt();
    ls_req = 1'b0;
    smp();
    chk("mf_no_rv_n3", c_ls_rvalid, 0);
    nxt();
    smp();
    chk("mf_no_rv_n4", c_ls_rvalid, 0);
    nxt();
    smp();
    chk("mf_rv_n5", c_ls_rvalid, 1);
    chk("mf_rdata", c_ls_rdata, 32'h1234_5678);
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
